// File: rtl/fp8x8_unpack_seq.sv
// Unpacks a 64-bit word of E5M2 FP8 lanes and streams the enabled lanes, one per cycle,
// through a single FP8->FP64 converter with lane index, tag and last-of-word flag.
module fp8x8_unpack_seq #(
  parameter int NLANES   = 8,
  parameter int TAGW     = 4,
  parameter bit ZERO_FIX = 1'b1,
  localparam int LW      = (NLANES > 1) ? $clog2(NLANES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [8*NLANES-1:0]   req_data,
  input  logic [NLANES-1:0]     req_mask,
  input  logic [TAGW-1:0]       req_tag,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [63:0]           res_data,
  output logic [LW-1:0]         res_lane,
  output logic [TAGW-1:0]       res_tag,
  output logic                  res_last,
  output logic                  busy,
  output logic [15:0]           words_done
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e               state_q, state_d;
  logic [8*NLANES-1:0]  data_q;
  logic [NLANES-1:0]    mask_q;
  logic [TAGW-1:0]      tag_q;
  logic [LW-1:0]        ptr_q;
  logic [15:0]          cnt_q;

  logic                 accept, fire, word_done, has_next;
  logic [LW-1:0]        first_lane, next_lane;
  logic [7:0]           lane_byte;

  // The lowest set bit is found by scanning downward so the last hit wins.
  function automatic logic [LW-1:0] lowest_set(input logic [NLANES-1:0] m);
    logic [LW-1:0] idx;
    idx = '0;
    for (int i = NLANES - 1; i >= 0; i--) begin
      if (m[i]) idx = LW'(i);
    end
    return idx;
  endfunction

  function automatic logic [63:0] fp8_to_fp64(input logic [7:0] b);
    logic        sgn;
    logic [4:0]  e;
    logic [1:0]  f;
    logic [10:0] e64;
    sgn = b[7];
    e   = b[6:2];
    f   = b[1:0];
    e64 = (e == 5'h1F) ? 11'h7FF : ({6'd0, e} + 11'h3F0);
    if (ZERO_FIX && (e == 5'd0)) return {sgn, 63'd0};
    return {sgn, e64, f, 50'd0};
  endfunction

  // Next enabled lane strictly above the pointer; has_next=0 marks the last lane.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    next_lane = '0;
    has_next  = 1'b0;
    for (int i = NLANES - 1; i >= 0; i--) begin
      if (mask_q[i] && (LW'(i) > ptr_q)) begin
        next_lane = LW'(i);
        has_next  = 1'b1;
      end
    end
  end

  assign first_lane = lowest_set(req_mask);
  assign lane_byte  = data_q[8*ptr_q +: 8];
  assign accept     = (state_q == IDLE) && req_valid;
  assign fire       = (state_q == RUN) && res_ready;
  assign word_done  = (accept && (req_mask == '0)) || (fire && !has_next);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid && (req_mask != '0)) state_d = RUN;
      RUN:     if (res_ready && !has_next)        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    busy      = (state_q == RUN);
    res_valid = (state_q == RUN);
  end

  always_ff @(posedge clk) begin
    // NOTE: captured word registers are reset too, so a dropped word leaves no stale lanes behind.
    if (rst) begin
      data_q <= '0;
      mask_q <= '0;
      tag_q  <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (accept) begin
        data_q <= req_data;
        mask_q <= req_mask;
        tag_q  <= req_tag;
        ptr_q  <= first_lane;
      end else if (fire && has_next) begin
        ptr_q  <= next_lane;
      end
      if (word_done) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign res_data   = fp8_to_fp64(lane_byte);
  assign res_lane   = ptr_q;
  assign res_tag    = tag_q;
  assign res_last   = !has_next;
  assign words_done = cnt_q;

endmodule

// File: tb/tb_fp8x8_unpack_seq.sv
// Directed bench: stimulus pushes hand-computed results into per-instance queues,
// negedge monitors compare every presented result (including stalled cycles) against the queue head.
module tb_fp8x8_unpack_seq;

  typedef struct {
    logic [63:0] data;
    logic [2:0]  lane;
    logic [3:0]  tag;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid0 = 1'b0, req_valid1 = 1'b0;
  logic [63:0] req_data = '0;
  logic [7:0]  req_mask = '0;
  logic [3:0]  req_tag = '0;
  logic        res_ready = 1'b1;
  logic        toggle_mode = 1'b0;

  logic        req_ready0, res_valid0, res_last0, busy0;
  logic [63:0] res_data0;
  logic [2:0]  res_lane0;
  logic [3:0]  res_tag0;
  logic [15:0] words_done0;
  logic        req_ready1, res_valid1, res_last1, busy1;
  logic [63:0] res_data1;
  logic [2:0]  res_lane1;
  logic [3:0]  res_tag1;
  logic [15:0] words_done1;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fp8x8_unpack_seq #(.NLANES(8), .TAGW(4), .ZERO_FIX(1'b1)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_data(req_data), .req_mask(req_mask), .req_tag(req_tag),
    .res_valid(res_valid0), .res_ready(res_ready), .res_data(res_data0),
    .res_lane(res_lane0), .res_tag(res_tag0), .res_last(res_last0),
    .busy(busy0), .words_done(words_done0));

  fp8x8_unpack_seq #(.NLANES(8), .TAGW(4), .ZERO_FIX(1'b0)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_data(req_data), .req_mask(req_mask), .req_tag(req_tag),
    .res_valid(res_valid1), .res_ready(res_ready), .res_data(res_data1),
    .res_lane(res_lane1), .res_tag(res_tag1), .res_last(res_last1),
    .busy(busy1), .words_done(words_done1));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int inst, input logic [63:0] d, input logic [2:0] lane,
                      input logic [3:0] tag, input logic last);
    exp_t e;
    e.data = d; e.lane = lane; e.tag = tag; e.last = last;
    if (inst == 0) q0.push_back(e);
    else           q1.push_back(e);
  endtask

  task automatic mon(input int inst, input logic v, input logic rdy, input logic [63:0] d,
                     input logic [2:0] lane, input logic [3:0] tag, input logic last);
    exp_t e;
    int   n;
    if (!v) return;
    n = (inst == 0) ? q0.size() : q1.size();
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_result inst%0d: got lane %0d data %h expected none", inst, lane, d);
      return;
    end
    e = (inst == 0) ? q0[0] : q1[0];
    check($sformatf("res_data inst%0d", inst), d, e.data);
    check($sformatf("res_lane inst%0d", inst), 64'(lane), 64'(e.lane));
    check($sformatf("res_tag inst%0d", inst), 64'(tag), 64'(e.tag));
    check($sformatf("res_last inst%0d", inst), 64'(last), 64'(e.last));
    if (rdy) begin
      if (inst == 0) void'(q0.pop_front());
      else           void'(q1.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, res_valid0, res_ready, res_data0, res_lane0, res_tag0, res_last0);
      mon(1, res_valid1, res_ready, res_data1, res_lane1, res_tag1, res_last1);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      res_ready = toggle_mode ? ~res_ready : 1'b1;
    end
  end

  task automatic send(input logic en0, input logic en1, input logic [63:0] d,
                      input logic [7:0] m, input logic [3:0] t);
    if (en0) check("req_ready0 before send", 64'(req_ready0), 64'd1);
    if (en1) check("req_ready1 before send", 64'(req_ready1), 64'd1);
    req_data = d; req_mask = m; req_tag = t;
    req_valid0 = en0; req_valid1 = en1;
    @(posedge clk);
    #1;
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    req_data = 64'hDEAD_BEEF_DEAD_BEEF; req_mask = 8'hFF; req_tag = 4'hF;
  endtask

  task automatic wait_idle(input int budget, output int cycles);
    cycles = 0;
    while ((busy0 || busy1) && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (busy0 || busy1) begin
      checks++;
      errors++;
      $display("FAIL wait_idle timeout: got busy after %0d cycles expected idle", cycles);
    end
  endtask

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset req_ready", 64'(req_ready0), 64'd1);
    check("reset res_valid", 64'(res_valid0), 64'd0);
    check("reset busy", 64'(busy0), 64'd0);
    check("reset words_done", 64'(words_done0), 64'd0);

    // single lane
    push(0, 64'h3FF0_0000_0000_0000, 3'd0, 4'd5, 1'b1);
    send(1'b1, 1'b0, 64'h0000_0000_0000_003C, 8'h01, 4'd5);
    wait_idle(50, cyc);
    check("t1 words_done", 64'(words_done0), 64'd1);

    // four back-to-back lanes
    push(0, 64'hC000_0000_0000_0000, 3'd0, 4'd9, 1'b0);
    push(0, 64'h3FF8_0000_0000_0000, 3'd1, 4'd9, 1'b0);
    push(0, 64'h7FF0_0000_0000_0000, 3'd2, 4'd9, 1'b0);
    push(0, 64'h7FF8_0000_0000_0000, 3'd3, 4'd9, 1'b1);
    send(1'b1, 1'b0, 64'h1111_1111_7E7C_3EC0, 8'h0F, 4'd9);
    wait_idle(50, cyc);
    check("t2 cycles for 4 results", 64'(cyc), 64'd4);
    check("t2 words_done", 64'(words_done0), 64'd2);

    // sparse mask with stalls
    toggle_mode = 1'b1;
    push(0, 64'h3FF0_0000_0000_0000, 3'd2, 4'd3, 1'b0);
    push(0, 64'hC000_0000_0000_0000, 3'd5, 4'd3, 1'b0);
    push(0, 64'h7FF8_0000_0000_0000, 3'd7, 4'd3, 1'b1);
    send(1'b1, 1'b0, 64'h7E55_C055_553C_5555, 8'hA4, 4'd3);
    wait_idle(50, cyc);
    toggle_mode = 1'b0;
    @(posedge clk);
    #1;
    check("t3 words_done", 64'(words_done0), 64'd3);

    // zero/denormal handling, both ZERO_FIX settings
    push(0, 64'h0000_0000_0000_0000, 3'd0, 4'd2, 1'b0);
    push(0, 64'h8000_0000_0000_0000, 3'd1, 4'd2, 1'b0);
    push(0, 64'h0000_0000_0000_0000, 3'd2, 4'd2, 1'b1);
    push(1, 64'h3F00_0000_0000_0000, 3'd0, 4'd2, 1'b0);
    push(1, 64'hBF00_0000_0000_0000, 3'd1, 4'd2, 1'b0);
    push(1, 64'h3F04_0000_0000_0000, 3'd2, 4'd2, 1'b1);
    send(1'b1, 1'b1, 64'h0000_0000_0001_8000, 8'h07, 4'd2);
    wait_idle(50, cyc);
    check("t4 words_done0", 64'(words_done0), 64'd4);
    check("t4 words_done1", 64'(words_done1), 64'd1);

    // empty mask
    send(1'b1, 1'b0, 64'h3C3C_3C3C_3C3C_3C3C, 8'h00, 4'd4);
    check("t5 req_ready after empty", 64'(req_ready0), 64'd1);
    check("t5 busy after empty", 64'(busy0), 64'd0);
    check("t5 words_done", 64'(words_done0), 64'd5);

    // counter wrap: reset, then 0xFFFF empty words
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("t5 words_done after rst", 64'(words_done0), 64'd0);
    req_mask = 8'h00;
    req_valid0 = 1'b1;
    repeat (65535) @(posedge clk);
    #1 req_valid0 = 1'b0;
    check("t5 words_done preload", 64'(words_done0), 64'hFFFF);
    push(0, 64'h3FF0_0000_0000_0000, 3'd0, 4'd1, 1'b1);
    send(1'b1, 1'b0, 64'h0000_0000_0000_003C, 8'h01, 4'd1);
    wait_idle(50, cyc);
    check("t5 words_done wrap", 64'(words_done0), 64'd0);
    send(1'b1, 1'b0, 64'h0, 8'h00, 4'd0);
    check("t6 words_done before", 64'(words_done0), 64'd1);

    // reset mid-word
    for (int i = 0; i < 8; i++) push(0, 64'h3FF0_0000_0000_0000, 3'(i), 4'd6, i == 7);
    send(1'b1, 1'b0, 64'h3C3C_3C3C_3C3C_3C3C, 8'hFF, 4'd6);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q0.delete();
    check("t6 res_valid after rst", 64'(res_valid0), 64'd0);
    check("t6 words_done after rst", 64'(words_done0), 64'd0);
    check("t6 busy after rst", 64'(busy0), 64'd0);
    for (int i = 0; i < 8; i++) push(0, 64'h3FF0_0000_0000_0000, 3'(i), 4'd7, i == 7);
    send(1'b1, 1'b0, 64'h3C3C_3C3C_3C3C_3C3C, 8'hFF, 4'd7);
    wait_idle(50, cyc);
    check("t6 words_done after word", 64'(words_done0), 64'd1);

    check("queue0 drained", 64'(q0.size()), 64'd0);
    check("queue1 drained", 64'(q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
